// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock (sig_in) in clk_in cycles,
// tracks lock against DIVISOR and flags mismatches and missing edges.
module clk_div_monitor #(
  parameter int unsigned DIVISOR    = 3,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  output logic             timeout
);

  localparam int unsigned MW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_C   = CNT_W'(DIVISOR);
  localparam logic [MW-1:0]    LOCK_C  = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_tmp_q, high_tmp_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic             meas_valid_q, meas_valid_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             timeout_q, timeout_d;
  logic [MW-1:0]    match_q, match_d;
  logic             rise, fall;

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    high_tmp_d   = high_tmp_q;
    period_d     = period_q;
    high_cnt_d   = high_cnt_q;
    meas_valid_d = 1'b0;
    locked_d     = locked_q;
    err_d        = 1'b0;
    timeout_d    = timeout_q;
    match_d      = match_q;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          cnt_d     = CNT_ONE;
          timeout_d = 1'b0;
          state_d   = HIGH;
        end
      end
      HIGH, LOW: begin
        if (rise) begin
          // a rise while still HIGH means the fall was missed: high time = full period
          period_d     = cnt_q;
          high_cnt_d   = (state_q == HIGH) ? cnt_q : high_tmp_q;
          meas_valid_d = 1'b1;
          cnt_d        = CNT_ONE;
          state_d      = HIGH;
          if (cnt_q == DIV_C) begin
            match_d  = (match_q == LOCK_C) ? match_q : match_q + MW'(1);
            locked_d = (match_d == LOCK_C);
          end else begin
            match_d  = '0;
            locked_d = 1'b0;
            err_d    = locked_q;
          end
        end else if (cnt_q == CNT_MAX - CNT_ONE) begin
          cnt_d     = CNT_MAX;
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          match_d   = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (state_q == HIGH && fall) begin
            high_tmp_d = cnt_q;
            state_d    = LOW;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      high_tmp_q   <= '0;
      period_q     <= '0;
      high_cnt_q   <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      timeout_q    <= 1'b0;
      match_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      high_tmp_q   <= high_tmp_d;
      period_q     <= period_d;
      high_cnt_q   <= high_cnt_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      timeout_q    <= timeout_d;
      match_q      <= match_d;
    end
  end

  assign period     = period_q;
  assign high_cnt   = high_cnt_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign err        = err_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: edge-timestamp reference model checked every cycle,
// a table of periodic patterns, and hand sequences for lock loss, timeout and reset.
module tb_clk_div_monitor;

  localparam int CW   = 8;
  localparam int DIV  = 3;
  localparam int LCK  = 4;
  localparam int SATE = (1 << CW) - 2;

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic          sig_in = 1'b0;
  logic [CW-1:0] period, high_cnt;
  logic          meas_valid, locked, err, timeout;

  clk_div_monitor #(.DIVISOR(DIV), .CNT_W(CW), .LOCK_COUNT(LCK)) dut (
    .clk_in(clk_in), .rst(rst), .sig_in(sig_in),
    .period(period), .high_cnt(high_cnt), .meas_valid(meas_valid),
    .locked(locked), .err(err), .timeout(timeout)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;
  int n_mv  = 0;
  int n_err = 0;

  // Reference model: sig_in as seen after the synchronizer, rise/fall edge
  // timestamps, and measurements as differences of those timestamps.
  bit m1, m2, m3;
  bit active;
  int edge_no, last_rise, fall_at;
  int mp, mh, mmatch;
  bit mmv, mlock, merr, mto;

  function automatic void model_edge(input bit s, input bit r);
    bit rz, fl;
    int el;
    if (r) begin
      m1 = 0; m2 = 0; m3 = 0; active = 0; fall_at = -1;
      mp = 0; mh = 0; mmatch = 0; mmv = 0; mlock = 0; merr = 0; mto = 0;
    end else begin
      rz = m2 & ~m3;
      fl = ~m2 & m3;
      mmv = 0; merr = 0;
      if (!active) begin
        if (rz) begin
          active = 1; last_rise = edge_no; fall_at = -1; mto = 0;
        end
      end else begin
        el = edge_no - last_rise;
        if (rz) begin
          mp  = el;
          mh  = (fall_at < 0) ? el : fall_at - last_rise;
          mmv = 1;
          if (el == DIV) begin
            mmatch = (mmatch + 1 > LCK) ? LCK : mmatch + 1;
            mlock  = (mmatch == LCK);
          end else begin
            merr = mlock; mmatch = 0; mlock = 0;
          end
          last_rise = edge_no; fall_at = -1;
        end else if (el == SATE) begin
          mto = 1; mlock = 0; mmatch = 0; active = 0;
        end else if (fl && fall_at < 0) begin
          fall_at = edge_no;
        end
      end
      m3 = m2; m2 = m1; m1 = s;
    end
    edge_no++;
  endfunction

  task automatic chk(input string name, input int got, input int expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, expv);
    end
  endtask

  task automatic step(input bit s, input bit r);
    logic [2*CW+3:0] got, expv;
    sig_in = s;
    rst    = r;
    @(posedge clk_in);
    model_edge(s, r);
    #1;
    got  = {period, high_cnt, meas_valid, locked, err, timeout};
    expv = {CW'(mp), CW'(mh), mmv, mlock, merr, mto};
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL model t=%0t got p=%0d h=%0d mv=%b lk=%b er=%b to=%b expected p=%0d h=%0d mv=%b lk=%b er=%b to=%b",
               $time, period, high_cnt, meas_valid, locked, err, timeout, mp, mh, mmv, mlock, merr, mto);
    end
    if (meas_valid === 1'b1) n_mv++;
    if (err === 1'b1) n_err++;
  endtask

  task automatic pulse(input int hi, input int lo);
    repeat (hi) step(1'b1, 1'b0);
    repeat (lo) step(1'b0, 1'b0);
  endtask

  typedef struct {
    int hi; int lo; int reps; int exp_p; int exp_h; int exp_lk;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{hi: 1, lo: 2, reps: 6, exp_p: 3, exp_h: 1, exp_lk: 1};
    tbl[1] = '{hi: 2, lo: 1, reps: 6, exp_p: 3, exp_h: 2, exp_lk: 1};
    tbl[2] = '{hi: 3, lo: 3, reps: 6, exp_p: 6, exp_h: 3, exp_lk: 0};
    tbl[3] = '{hi: 2, lo: 2, reps: 6, exp_p: 4, exp_h: 2, exp_lk: 0};
    tbl[4] = '{hi: 1, lo: 1, reps: 6, exp_p: 2, exp_h: 1, exp_lk: 0};
    tbl[5] = '{hi: 4, lo: 5, reps: 5, exp_p: 9, exp_h: 4, exp_lk: 0};

    edge_no = 0;
    model_edge(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    chk("reset_outputs", int'({period, high_cnt, meas_valid, locked, err, timeout}), 0);
    repeat (2) step(1'b0, 1'b0);

    // periodic patterns
    foreach (tbl[i]) begin
      n_err = 0;
      repeat (tbl[i].reps) pulse(tbl[i].hi, tbl[i].lo);
      chk($sformatf("tbl%0d_period", i), int'(period), tbl[i].exp_p);
      chk($sformatf("tbl%0d_high", i), int'(high_cnt), tbl[i].exp_h);
      chk($sformatf("tbl%0d_locked", i), int'(locked), tbl[i].exp_lk);
    end

    // lock, one long period, relock
    repeat (6) pulse(1, 2);
    chk("pre_inject_locked", int'(locked), 1);
    n_err = 0;
    pulse(1, 3);
    pulse(1, 2);
    chk("inject_period", int'(period), 4);
    chk("inject_locked", int'(locked), 0);
    repeat (4) pulse(1, 2);
    chk("inject_err_pulses", n_err, 1);
    chk("relock", int'(locked), 1);

    // timeout after a long low, then a rise clears it without a measurement
    repeat (300) step(1'b0, 1'b0);
    chk("timeout_set", int'(timeout), 1);
    chk("timeout_unlock", int'(locked), 0);
    n_mv = 0;
    pulse(1, 2);
    chk("timeout_cleared", int'(timeout), 0);
    chk("timeout_no_meas", n_mv, 0);

    // reset mid-LOW while locked
    repeat (6) pulse(1, 2);
    chk("pre_reset_locked", int'(locked), 1);
    pulse(1, 1);
    step(1'b0, 1'b1);
    chk("midreset_outputs", int'({period, high_cnt, meas_valid, locked, err, timeout}), 0);
    n_mv = 0;
    repeat (2) pulse(1, 2);
    chk("after_reset_meas", n_mv, 1);

    // isolated single-cycle glitches
    step(1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0);
    n_mv = 0;
    pulse(1, 3);
    pulse(1, 10);
    chk("glitch_meas", n_mv, 1);
    chk("glitch_period", int'(period), 4);
    chk("glitch_high", int'(high_cnt), 1);
    chk("glitch_nolock", int'(locked), 0);

    // random mix: mostly in-spec pulses, some off-spec, rare long gaps and resets
    for (int k = 0; k < 400; k++) begin
      int sel;
      sel = int'($urandom_range(0, 39));
      if (sel == 0) step(1'b0, 1'b1);
      else if (sel == 1) pulse(1, 260);
      else if (sel == 2) pulse(258, 2);
      else if (sel < 24) pulse(1, 2);
      else pulse(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
